// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel servo PWM generator with a shared frame
// counter, per-channel clamped targets and frame-synchronous width updates.
// Ports: clock/reset (async, active high); cmd_valid/cmd_ready/cmd_ch/
// cmd_width command port; cmd_err bad-channel pulse; ch_enable per-channel
// enable; pwm_out registered pulses; frame_tick last frame cycle; at_target
// active == target per channel.
// Option: define SERVO_SLEW_LIMIT_EN to limit width change per frame to
// SLEW_STEP cycles; otherwise the new target takes effect next frame.
module servo_pwm_array #(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 1000000,
    parameter int MIN_PULSE = 50000,
    parameter int MAX_PULSE = 100000,
    parameter int SLEW_STEP = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_ch,
    input  logic [CNT_W-1:0]  cmd_width,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick,
    output logic [NUM_CH-1:0] at_target,
    output logic              cmd_err
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] MID_W = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  target   [NUM_CH];
    logic [CNT_W-1:0]  active   [NUM_CH];
    logic [CNT_W-1:0]  next_act [NUM_CH];
    logic [NUM_CH-1:0] en_sh;
    logic [CNT_W-1:0]  clamped;
    logic              accept;
    logic              bad_ch;

    assign frame_tick = (cnt == LAST);
    // Commands are refused in the frame-boundary cycle so a target write
    // never races the active-width update.
    assign cmd_ready  = ~reset & ~frame_tick;
    assign accept     = cmd_valid & cmd_ready;
    assign bad_ch     = (int'(cmd_ch) >= NUM_CH);

    always_comb begin
        clamped = cmd_width;
        if (cmd_width < MIN_W)
            clamped = MIN_W;
        else if (cmd_width > MAX_W)
            clamped = MAX_W;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            at_target[i] = (active[i] == target[i]);
    end

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SLEW_STEP);

    // Ramp from the current active width, so a retarget mid-ramp continues
    // smoothly from where the output is now.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            next_act[i] = active[i];
            if (target[i] > active[i])
                next_act[i] = (target[i] - active[i] > STEP) ?
                              active[i] + STEP : target[i];
            else if (target[i] < active[i])
                next_act[i] = (active[i] - target[i] > STEP) ?
                              active[i] - STEP : target[i];
        end
    end
`else
    logic [CNT_W-1:0] unused_step;
    assign unused_step = CNT_W'(SLEW_STEP);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            next_act[i] = target[i];
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (frame_tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cmd_err <= 1'b0;
        else
            cmd_err <= accept & bad_ch;
    end

    // Active widths and enables only change at the frame boundary, so a
    // pulse in flight is never cut short or stretched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= MID_W;
                active[i] <= MID_W;
            end
            en_sh   <= '0;
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= en_sh[i] & (cnt < active[i]);
                if (accept && !bad_ch && cmd_ch == 4'(i))
                    target[i] <= clamped;
                if (frame_tick)
                    active[i] <= next_act[i];
            end
            if (frame_tick)
                en_sh <= ch_enable;
        end
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array: randomized and directed bench for servo_pwm_array
// against a frame-level behavioural model.
module tb_servo_pwm_array;

    localparam int NCH  = 3;
    localparam int W    = 20;
    localparam int PER  = 100;
    localparam int MINP = 10;
    localparam int MAXP = 20;
    localparam int STEP = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic [3:0]     cmd_ch = '0;
    logic [W-1:0]   cmd_width = '0;
    logic [NCH-1:0] ch_enable = '0;
    logic           cmd_ready;
    logic [NCH-1:0] pwm_out;
    logic           frame_tick;
    logic [NCH-1:0] at_target;
    logic           cmd_err;

    servo_pwm_array #(
        .NUM_CH(NCH), .CNT_W(W), .PERIOD(PER),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .SLEW_STEP(STEP)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_width(cmd_width),
        .ch_enable(ch_enable), .pwm_out(pwm_out),
        .frame_tick(frame_tick), .at_target(at_target),
        .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state: frame position, targets, active widths, enables.
    int m_cnt;
    int m_tgt [NCH];
    int m_act [NCH];
    bit m_en  [NCH];
    int hw    [NCH];
    logic [NCH-1:0] e_pwm, e_at;
    logic e_tick, e_rdy, e_err;

    function automatic int clampw(int w);
        if (w < MINP) return MINP;
        if (w > MAXP) return MAXP;
        return w;
    endfunction

    function automatic int approach(int a, int t);
`ifdef SERVO_SLEW_LIMIT_EN
        if (t - a > STEP) return a + STEP;
        if (a - t > STEP) return a - STEP;
        return t;
`else
        return t + 0 * a;
`endif
    endfunction

    task automatic derive();
        e_tick = (m_cnt == PER - 1);
        e_rdy  = !e_tick && !reset;
        for (int i = 0; i < NCH; i++)
            e_at[i] = (m_act[i] == m_tgt[i]);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = (MINP + MAXP) / 2;
            m_act[i] = (MINP + MAXP) / 2;
            m_en[i]  = 1'b0;
        end
        e_pwm = '0;
        e_err = 1'b0;
        derive();
    endtask

    // One clock: advance the model with the inputs seen at the edge.
    task automatic step();
        bit fire;
        @(posedge clock);
        fire = (m_cnt == PER - 1);
        for (int i = 0; i < NCH; i++)
            e_pwm[i] = m_en[i] && (m_cnt < m_act[i]);
        e_err = 1'b0;
        if (cmd_valid && !fire) begin
            if (int'(cmd_ch) >= NCH)
                e_err = 1'b1;
            else
                m_tgt[cmd_ch] = clampw(int'(cmd_width));
        end
        if (fire) begin
            for (int i = 0; i < NCH; i++) begin
                m_act[i] = approach(m_act[i], m_tgt[i]);
                m_en[i]  = ch_enable[i];
            end
        end
        m_cnt = fire ? 0 : m_cnt + 1;
        #1;
        derive();
    endtask

    task automatic wait_to(int k);
        int n = 0;
        while (m_cnt != k && n < 2 * PER) begin
            step();
            n++;
        end
    endtask

    // Count high cycles per channel over one whole frame.
    task automatic measure_frame();
        wait_to(0);
        for (int i = 0; i < NCH; i++) hw[i] = 0;
        repeat (PER) begin
            step();
            for (int i = 0; i < NCH; i++) hw[i] += int'(pwm_out[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        cmd_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        derive();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (pwm_out !== 3'b000) begin
            failures++;
            $display("FAIL rst_pwm got=%b want=000", pwm_out);
        end
        checks++;
        if (frame_tick !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_tick_rdy got=%b%b want=00",
                     frame_tick, cmd_ready);
        end
        checks++;
        if (cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_err got=%b want=0", cmd_err);
        end
        checks++;
        if (at_target !== 3'b111) begin
            failures++;
            $display("FAIL rst_at got=%b want=111", at_target);
        end
        reset = 1'b0;
        #1;
        derive();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rel_rdy got=%b want=1", cmd_ready);
        end
    endtask

    task automatic test_idle();
        int last = -1;
        ch_enable = 3'b111;
        for (int n = 0; n < 250; n++) begin
            step();
            checks++;
            if ({pwm_out, at_target, frame_tick, cmd_ready, cmd_err} !==
                {e_pwm, e_at, e_tick, e_rdy, e_err}) begin
                failures++;
                $display("FAIL idle n=%0d got=%b%b%b%b%b want=%b%b%b%b%b",
                         n, pwm_out, at_target, frame_tick, cmd_ready,
                         cmd_err, e_pwm, e_at, e_tick, e_rdy, e_err);
            end
            if (frame_tick) begin
                if (last >= 0) begin
                    checks++;
                    if (n - last != PER) begin
                        failures++;
                        $display("FAIL tick_gap got=%0d want=%0d",
                                 n - last, PER);
                    end
                end
                last = n;
            end
        end
        measure_frame();
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (hw[i] != 15) begin
                failures++;
                $display("FAIL idle_width ch%0d got=%0d want=15", i, hw[i]);
            end
        end
    endtask

    task automatic test_clamp();
        wait_to(30);
        cmd_valid = 1'b1; cmd_ch = 4'd0; cmd_width = 20'd40;
        step();
        cmd_ch = 4'd1; cmd_width = 20'd2;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (m_tgt[0] != 20 || m_tgt[1] != 10 || at_target !== e_at) begin
            failures++;
            $display("FAIL clamp_at got=%b want=%b", at_target, e_at);
        end
        wait_to(PER - 1);
        checks++;
        if (cmd_ready !== 1'b0 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL tick_rdy got=%b%b want=10", frame_tick, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_ch = 4'd2; cmd_width = 20'd20;
        step();
        cmd_valid = 1'b0;
        measure_frame();
        checks++;
`ifdef SERVO_SLEW_LIMIT_EN
        if (hw[0] != 18 || at_target[0] !== 1'b0) begin
            failures++;
            $display("FAIL slew_f1 got=%0d/%b want=18/0", hw[0], at_target[0]);
        end
`else
        if (hw[0] != 20 || at_target[0] !== 1'b1) begin
            failures++;
            $display("FAIL copy_f1 got=%0d/%b want=20/1", hw[0], at_target[0]);
        end
`endif
        measure_frame();
        checks++;
        if (hw[0] != 20 || hw[1] != 10 || hw[2] != 15 ||
            at_target !== 3'b111) begin
            failures++;
            $display("FAIL clamp_w got=%0d,%0d,%0d at=%b want=20,10,15 111",
                     hw[0], hw[1], hw[2], at_target);
        end
    endtask

    task automatic test_err();
        wait_to(20);
        cmd_valid = 1'b1; cmd_ch = 4'd5; cmd_width = 20'd12;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse got=%b want=1", cmd_err);
        end
        step();
        checks++;
        if (cmd_err !== 1'b0 || at_target !== 3'b111) begin
            failures++;
            $display("FAIL err_end got=%b at=%b want=0 111", cmd_err, at_target);
        end
        measure_frame();
        checks++;
        if (hw[0] != 20 || hw[1] != 10 || hw[2] != 15) begin
            failures++;
            $display("FAIL err_tgt got=%0d,%0d,%0d want=20,10,15",
                     hw[0], hw[1], hw[2]);
        end
    endtask

    task automatic test_enable();
        int h2 = 0;
        wait_to(5);
        ch_enable[2] = 1'b0;
        while (m_cnt != 0) begin
            step();
            h2 += int'(pwm_out[2]);
        end
        checks++;
        if (h2 != 10) begin
            failures++;
            $display("FAIL en_tail got=%0d want=10", h2);
        end
        measure_frame();
        checks++;
        if (hw[2] != 0 || hw[0] != 20) begin
            failures++;
            $display("FAIL en_off got=%0d,%0d want=0,20", hw[2], hw[0]);
        end
        ch_enable = 3'b111;
    endtask

    task automatic test_slew_retarget();
        int h0 = 0;
        do_reset();
        ch_enable = 3'b111;
        wait_to(40);
        cmd_valid = 1'b1; cmd_ch = 4'd0; cmd_width = 20'd20;
        step();
        cmd_valid = 1'b0;
        wait_to(0);
        for (int n = 0; n < PER; n++) begin
            cmd_valid = (n == 50);
            cmd_ch = 4'd0; cmd_width = 20'd10;
            step();
            h0 += int'(pwm_out[0]);
        end
        cmd_valid = 1'b0;
        checks++;
`ifdef SERVO_SLEW_LIMIT_EN
        if (h0 != 18) begin
`else
        if (h0 != 20) begin
`endif
            failures++;
            $display("FAIL rt_f1 got=%0d", h0);
        end
        measure_frame();
        checks++;
`ifdef SERVO_SLEW_LIMIT_EN
        if (hw[0] != 15) begin
`else
        if (hw[0] != 10) begin
`endif
            failures++;
            $display("FAIL rt_f2 got=%0d", hw[0]);
        end
        measure_frame();
        checks++;
`ifdef SERVO_SLEW_LIMIT_EN
        if (hw[0] != 12) begin
`else
        if (hw[0] != 10) begin
`endif
            failures++;
            $display("FAIL rt_f3 got=%0d", hw[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wait_to(0);
        wait_to(0);
        wait_to(50);
        cmd_valid = 1'b1; cmd_ch = 4'd0; cmd_width = 20'd20;
        step();
        cmd_valid = 1'b0;
        wait_to(0);
        wait_to(7);
        checks++;
        if (pwm_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst got=%b want=1", pwm_out[0]);
        end
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (pwm_out !== 3'b000 || at_target !== 3'b111) begin
            failures++;
            $display("FAIL async_rst got=%b at=%b want=000 111",
                     pwm_out, at_target);
        end
        @(negedge clock);
        reset = 1'b0;
        derive();
        while (!frame_tick && n < 3 * PER) begin
            step();
            n++;
        end
        checks++;
        if (n != PER - 1) begin
            failures++;
            $display("FAIL restart got=%0d want=%0d", n, PER - 1);
        end
        measure_frame();
        checks++;
        if (hw[0] != 15 || hw[1] != 15 || hw[2] != 15) begin
            failures++;
            $display("FAIL post_rst got=%0d,%0d,%0d want=15",
                     hw[0], hw[1], hw[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_ch    = 4'($urandom_range(0, 4));
            cmd_width = W'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0)
                ch_enable = NCH'($urandom_range(0, 7));
            step();
            checks++;
            if ({pwm_out, at_target, frame_tick, cmd_ready, cmd_err} !==
                {e_pwm, e_at, e_tick, e_rdy, e_err}) begin
                failures++;
                $display("FAIL rand n=%0d got=%b%b%b%b%b want=%b%b%b%b%b",
                         n, pwm_out, at_target, frame_tick, cmd_ready,
                         cmd_err, e_pwm, e_at, e_tick, e_rdy, e_err);
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_clamp();
        test_err();
        test_enable();
        test_slew_retarget();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
